// File: rtl/seg_display_selector.sv
// Seven-segment source selector for the HEX display path: picks one of NSRC digit groups,
// latches per-source overflow errors and shows a (optionally blinking) "Erro" message.
module seg_display_selector #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned NSRC      = 2,
  parameter int unsigned SELW      = 1,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                      CLOCK_50,
  input  logic                      RST,
  input  logic [SELW-1:0]           sel,
  input  logic [NSRC*DIGITS*7-1:0]  src_seg,
  input  logic [NSRC-1:0]           overflow,
  input  logic                      err_clear,
  input  logic                      blink_en,
  output logic [DIGITS*7-1:0]       seg_out,
  output logic                      err_active
);

  localparam int unsigned SegW = DIGITS * 7;
  localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

  localparam logic [6:0] SegE     = 7'b0000110;
  localparam logic [6:0] SegR     = 7'b0101111;
  localparam logic [6:0] SegO     = 7'b0100011;

  logic [SELW-1:0] sel_meta_q;
  logic [SELW-1:0] sel_s_q;
  logic [NSRC-1:0] err_q;
  logic [NSRC-1:0] err_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            phase_off_q;
  logic            phase_off_d;
  logic [SegW-1:0] seg_d;
  logic            err_active_d;

  logic            in_range;
  logic            src_err;
  logic [SegW-1:0] src_digits;
  logic [SegW-1:0] err_pattern;
  logic            emode;
  logic            entering;
  logic [CntW-1:0] cur_cnt;
  logic            cur_off;

  // Set has priority over clear so an overflow coinciding with err_clear is never lost.
  always_comb begin
    err_d = overflow | (err_q & ~{NSRC{err_clear}});
  end

  always_comb begin
    in_range   = 1'b0;
    src_err    = 1'b0;
    src_digits = '1;
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (32'(sel_s_q) == s) begin
        in_range   = 1'b1;
        src_err    = err_q[s] | overflow[s];
        src_digits = src_seg[s*SegW +: SegW];
      end
    end
  end

  always_comb begin
    err_pattern        = '1;
    err_pattern[27:21] = SegE;
    err_pattern[20:14] = SegR;
    err_pattern[13:7]  = SegR;
    err_pattern[6:0]   = SegO;
  end

  assign emode    = in_range & src_err;
  // A fresh error entry always starts the blink sequence at the ON phase.
  assign entering = emode & ~err_active;
  assign cur_cnt  = entering ? '0 : cnt_q;
  assign cur_off  = entering ? 1'b0 : phase_off_q;

  always_comb begin
    cnt_d        = '0;
    phase_off_d  = 1'b0;
    seg_d        = '1;
    err_active_d = emode;
    if (emode) begin
      if (blink_en) begin
        if (cur_cnt == CntMax) begin
          cnt_d       = '0;
          phase_off_d = ~cur_off;
        end else begin
          cnt_d       = cur_cnt + CntW'(1);
          phase_off_d = cur_off;
        end
        seg_d = cur_off ? '1 : err_pattern;
      end else begin
        seg_d = err_pattern;
      end
    end else if (in_range) begin
      seg_d = src_digits;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sel_meta_q  <= '0;
      sel_s_q     <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      phase_off_q <= 1'b0;
      seg_out     <= '1;
      err_active  <= 1'b0;
    end else begin
      sel_meta_q  <= sel;
      sel_s_q     <= sel_meta_q;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      phase_off_q <= phase_off_d;
      seg_out     <= seg_d;
      err_active  <= err_active_d;
    end
  end

endmodule

// File: tb/tb_seg_display_selector.sv
// Scoreboard bench for seg_display_selector: a cycle-level reference model pushes expected
// outputs into a queue, and a monitor pops and compares them after every clock edge.
module tb_seg_display_selector;

  localparam int DIGITS    = 5;
  localparam int NSRC      = 3;
  localparam int SELW      = 2;
  localparam int BLINK_DIV = 4;
  localparam int SW        = DIGITS * 7;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [SELW-1:0]        sel;
  logic [NSRC*SW-1:0]     src_seg;
  logic [NSRC-1:0]        overflow;
  logic                   err_clear;
  logic                   blink_en;
  logic [SW-1:0]          seg_out;
  logic                   err_active;

  always #5 clk = ~clk;

  seg_display_selector #(
    .DIGITS   (DIGITS),
    .NSRC     (NSRC),
    .SELW     (SELW),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .CLOCK_50  (clk),
    .RST       (rst),
    .sel       (sel),
    .src_seg   (src_seg),
    .overflow  (overflow),
    .err_clear (err_clear),
    .blink_en  (blink_en),
    .seg_out   (seg_out),
    .err_active(err_active)
  );

  typedef struct packed {
    logic [SW-1:0] seg;
    logic          act;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: sel pipeline, sticky flags, cycles spent blinking in error mode.
  int   m_sync0, m_sync1;
  bit   m_err[NSRC];
  int   m_elapsed;

  function automatic logic [SW-1:0] err_word();
    logic [SW-1:0] w;
    for (int d = 0; d < DIGITS; d++) begin
      case (d)
        3:       w[d*7 +: 7] = 7'b0000110;
        2, 1:    w[d*7 +: 7] = 7'b0101111;
        0:       w[d*7 +: 7] = 7'b0100011;
        default: w[d*7 +: 7] = 7'h7F;
      endcase
    end
    return w;
  endfunction

  task automatic model_reset();
    m_sync0   = 0;
    m_sync1   = 0;
    m_elapsed = 0;
    for (int s = 0; s < NSRC; s++) m_err[s] = 1'b0;
  endtask

  // Inputs are already driven; predict the output of the coming edge, then advance a cycle.
  task automatic cycle();
    exp_t e;
    int   ss;
    bit   em;
    ss    = m_sync1;
    em    = (ss < NSRC) && (m_err[ss] || overflow[ss]);
    e.act = em;
    e.seg = '1;
    if (em) begin
      if (blink_en) begin
        if (((m_elapsed / BLINK_DIV) % 2) == 0) e.seg = err_word();
        m_elapsed++;
      end else begin
        e.seg     = err_word();
        m_elapsed = 0;
      end
    end else begin
      m_elapsed = 0;
      if (ss < NSRC) e.seg = src_seg[ss*SW +: SW];
    end
    for (int s = 0; s < NSRC; s++) m_err[s] = overflow[s] | (m_err[s] & !err_clear);
    m_sync1 = m_sync0;
    m_sync0 = int'(sel);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_blank(input string name);
    checks++;
    if (seg_out !== {SW{1'b1}} || err_active !== 1'b0) begin
      errors++;
      $display("FAIL %s: seg_out=%h err_active=%b, required seg_out=%h err_active=0",
               name, seg_out, err_active, {SW{1'b1}});
    end
  endtask

  // Entered just after a negedge, when no prediction is pending.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_blank("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_blank("held_reset");
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (seg_out !== e.seg || err_active !== e.act) begin
          errors++;
          $display("FAIL scoreboard cycle %0d: seg_out=%h err_active=%b, required %h %b",
                   cyc, seg_out, err_active, e.seg, e.act);
        end
      end
      cyc++;
    end
  end

  initial begin : stimulus
    rst       = 1'b1;
    sel       = '0;
    overflow  = '0;
    err_clear = 1'b0;
    blink_en  = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      src_seg[(0*DIGITS+d)*7 +: 7] = 7'h40;
      src_seg[(1*DIGITS+d)*7 +: 7] = 7'h79;
      src_seg[(2*DIGITS+d)*7 +: 7] = 7'h24;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_blank("initial_reset");
    rst = 1'b0;

    // Normal selection and the 3-clock sel latency.
    repeat (4) cycle();
    sel = 2'd1;
    repeat (5) cycle();
    sel = 2'd0;
    repeat (4) cycle();

    // Sticky error then clear.
    overflow = 3'b001;
    cycle();
    overflow = '0;
    repeat (3) cycle();
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    repeat (2) cycle();

    // Set/clear collision.
    overflow = 3'b001;
    cycle();
    overflow = '0;
    cycle();
    overflow  = 3'b010;
    err_clear = 1'b1;
    cycle();
    overflow  = '0;
    err_clear = 1'b0;
    cycle();
    sel = 2'd1;
    repeat (4) cycle();
    sel = 2'd0;
    repeat (4) cycle();
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;
    cycle();

    // Blink sequence, blink_en toggled mid-blink.
    blink_en = 1'b1;
    overflow = 3'b001;
    cycle();
    overflow = '0;
    repeat (12) cycle();
    blink_en = 1'b0;
    repeat (2) cycle();
    blink_en = 1'b1;
    repeat (6) cycle();

    // Reset during the OFF phase; sync flops must restart at 0.
    sel = 2'd1;
    do_reset();
    blink_en = 1'b0;
    repeat (5) cycle();

    // Out-of-range select with the source-2 flag set.
    overflow = 3'b100;
    cycle();
    overflow = '0;
    sel = 2'd3;
    repeat (4) cycle();
    sel = 2'd2;
    repeat (5) cycle();
    err_clear = 1'b1;
    cycle();
    err_clear = 1'b0;

    // Randomised traffic.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) sel = SELW'($urandom_range(0, 3));
      overflow  = ($urandom_range(0, 11) == 0) ? NSRC'($urandom) : '0;
      err_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 29) == 0) blink_en = ~blink_en;
      for (int i = 0; i < NSRC * DIGITS; i++) src_seg[i*7 +: 7] = 7'($urandom);
      cycle();
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
